// File: rtl/mult_bus_if.sv
// Register-bus link between mult_bus_master and the memory-mapped multiplier peripheral.
// bus_rdata is registered by the peripheral and is valid the cycle after cs&rd.
interface mult_bus_if;
    logic        bus_cs;
    logic [4:0]  bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_cs, bus_addr, bus_rd, bus_wr, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_cs, bus_addr, bus_rd, bus_wr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/mult_bus_master.sv
// Bus initiator for the multiplier peripheral: writes A, B and init, polls done,
// reads the product, clears init and returns the result with a one-cycle valid.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start
// WR_CLR   | write init=0 on the bus, so the later init=1 is a rising edge
// WR_A     | write operand A on the bus
// WR_B     | write operand B on the bus
// WR_INIT  | write init=1 on the bus
// POLL_REQ | done read on the bus
// POLL_CHK | done read data present; decide done / poll again / abort
// RD_REQ   | result read on the bus
// RD_CAP   | result read data present; capture it
// WR_FIN   | write init=0 on the bus
// RESP     | valid pulse, back to IDLE
module mult_bus_master #(
    parameter logic [4:0] ADDR_A    = 5'h04,
    parameter logic [4:0] ADDR_B    = 5'h08,
    parameter logic [4:0] ADDR_INIT = 5'h0C,
    parameter logic [4:0] ADDR_RES  = 5'h10,
    parameter logic [4:0] ADDR_DONE = 5'h14,
    parameter int         TIMEOUT   = 1024,
    parameter int         CNT_W     = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result,
    output logic        timeout_err,
    mult_bus_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE, WR_CLR, WR_A, WR_B, WR_INIT, POLL_REQ,
        POLL_CHK, RD_REQ, RD_CAP, WR_FIN, RESP
    } state_t;

    state_t             state;
    logic [15:0]        a_q;
    logic [15:0]        b_q;
    logic               abort;
    logic [CNT_W-1:0]   poll_cnt;
    logic [CNT_W-1:0]   poll_cnt_inc;

    assign poll_cnt_inc = poll_cnt + CNT_W'(1);

    // Bus outputs are registered on entry to the state that owns the access,
    // so the strobe is on the bus during the cycle that state is current.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            abort         <= 1'b0;
            poll_cnt      <= '0;
            busy          <= 1'b0;
            valid         <= 1'b0;
            result        <= '0;
            timeout_err   <= 1'b0;
            bus.bus_cs    <= 1'b0;
            bus.bus_rd    <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
        end else begin
            bus.bus_cs <= 1'b0;
            bus.bus_rd <= 1'b0;
            bus.bus_wr <= 1'b0;
            valid      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q           <= op_a;
                        b_q           <= op_b;
                        abort         <= 1'b0;
                        busy          <= 1'b1;
                        bus.bus_cs    <= 1'b1;
                        bus.bus_wr    <= 1'b1;
                        bus.bus_addr  <= ADDR_INIT;
                        bus.bus_wdata <= 16'h0000;
                        state         <= WR_CLR;
                    end
                end
                WR_CLR: begin
                    bus.bus_cs    <= 1'b1;
                    bus.bus_wr    <= 1'b1;
                    bus.bus_addr  <= ADDR_A;
                    bus.bus_wdata <= a_q;
                    state         <= WR_A;
                end
                WR_A: begin
                    bus.bus_cs    <= 1'b1;
                    bus.bus_wr    <= 1'b1;
                    bus.bus_addr  <= ADDR_B;
                    bus.bus_wdata <= b_q;
                    state         <= WR_B;
                end
                WR_B: begin
                    bus.bus_cs    <= 1'b1;
                    bus.bus_wr    <= 1'b1;
                    bus.bus_addr  <= ADDR_INIT;
                    bus.bus_wdata <= 16'h0001;
                    state         <= WR_INIT;
                end
                WR_INIT: begin
                    poll_cnt     <= '0;
                    bus.bus_cs   <= 1'b1;
                    bus.bus_rd   <= 1'b1;
                    bus.bus_addr <= ADDR_DONE;
                    state        <= POLL_REQ;
                end
                POLL_REQ: begin
                    state <= POLL_CHK;
                end
                POLL_CHK: begin
                    if (bus.bus_rdata[0]) begin
                        bus.bus_cs   <= 1'b1;
                        bus.bus_rd   <= 1'b1;
                        bus.bus_addr <= ADDR_RES;
                        state        <= RD_REQ;
                    end else begin
                        poll_cnt <= poll_cnt_inc;
                        // Timeout only counts polls that came back not-done.
                        if (poll_cnt_inc == CNT_W'(TIMEOUT)) begin
                            abort         <= 1'b1;
                            bus.bus_cs    <= 1'b1;
                            bus.bus_wr    <= 1'b1;
                            bus.bus_addr  <= ADDR_INIT;
                            bus.bus_wdata <= 16'h0000;
                            state         <= WR_FIN;
                        end else begin
                            bus.bus_cs   <= 1'b1;
                            bus.bus_rd   <= 1'b1;
                            bus.bus_addr <= ADDR_DONE;
                            state        <= POLL_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    result        <= bus.bus_rdata;
                    bus.bus_cs    <= 1'b1;
                    bus.bus_wr    <= 1'b1;
                    bus.bus_addr  <= ADDR_INIT;
                    bus.bus_wdata <= 16'h0000;
                    state         <= WR_FIN;
                end
                WR_FIN: begin
                    valid       <= 1'b1;
                    busy        <= 1'b0;
                    timeout_err <= abort;
                    if (abort) begin
                        result <= '0;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_bus_master.md
Name: mult_bus_master

Overview:
- Bus initiator that drives the memory-mapped multiplier peripheral from the other side of its cs/addr/rd/wr interface.
- Accepts an operand pair on a start strobe, then issues the register-write sequence (A, B, init).
- Polls the done register, reads the 32-bit result, clears init, and returns the product with a one-cycle valid pulse.
- Sits between a simple compute client (FSM or test harness) and the multiplier peripheral, replacing CPU software for that job.

Parameters:
ADDR_A, 5'h04, write address of operand A
ADDR_B, 5'h08, write address of operand B
ADDR_INIT, 5'h0C, write address of init (bit 0)
ADDR_RES, 5'h10, read address of 32-bit result
ADDR_DONE, 5'h14, read address of done (bit 0)
TIMEOUT, 1024, max done-polls (with done=0) before abort; >=1
CNT_W, 11, width of poll counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request; sampled only in IDLE
op_a  in  16  operand A, captured when start is accepted
op_b  in  16  operand B, captured when start is accepted
busy  out  1  high from the cycle after acceptance until valid
valid  out  1  one-cycle pulse: result/timeout_err are valid
result  out  32  product; held until the next valid
timeout_err  out  1  qualifies valid; 1 = aborted, result=0
bus_cs  out  1  peripheral chip select
bus_addr  out  5  peripheral address
bus_rd  out  1  read strobe
bus_wr  out  1  write strobe
bus_wdata  out  16  write data
bus_rdata  in  32  peripheral read data; registered by the peripheral, valid the cycle after cs&rd

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy, valid, timeout_err, bus_cs, bus_rd, bus_wr = 0.
  - bus_addr=0, bus_wdata=0, result=0, poll counter=0.
  - Reset asserted mid-transaction drops all strobes immediately; no cleanup write is issued.
- All outputs are registered. Bus strobes last exactly one cycle per access. bus_cs=1 exactly when bus_rd or bus_wr is 1.
- States and transitions, one cycle each unless noted:
  - IDLE: on start=1, capture op_a/op_b, go to WR_CLR. start is ignored in every other state.
  - WR_CLR: write ADDR_INIT with 0, guaranteeing an init rising edge later.
  - WR_A: write ADDR_A with op_a.
  - WR_B: write ADDR_B with op_b.
  - WR_INIT: write ADDR_INIT with 16'h0001; clear the poll counter.
  - POLL_REQ: read ADDR_DONE.
  - POLL_CHK: no strobe; examine bus_rdata[0].
    - If 1, go to RD_REQ.
    - Else increment the counter. If counter==TIMEOUT, set the abort flag and go to WR_FIN; else go to POLL_REQ.
  - RD_REQ: read ADDR_RES.
  - RD_CAP: capture bus_rdata into result.
  - WR_FIN: write ADDR_INIT with 0.
  - RESP: valid=1. timeout_err equals the abort flag; result=0 if aborted. busy=0. Go to IDLE.
- Latency:
  - Define start accepted at edge 0.
  - Writes occur in cycles 1-4, first poll in cycle 5.
  - If done is seen at the first poll, valid is in cycle 10.
  - Each extra poll adds 2 cycles.
  - A new start is accepted the cycle after valid, so back-to-back operations have no dead cycle beyond that.
- Width rules:
  - Only bus_rdata[0] is used for done; upper bits are ignored.
  - Write data for init is zero-extended.
  - result is the full 32 bits, not truncated.
- Simultaneous events:
  - start during RESP is ignored. It is honoured only once the state reads IDLE, on the next cycle.
  - Timeout is checked only after a done=0 poll. If done=1 arrives on poll number TIMEOUT, it succeeds.

Test Plan:
- Normal op with a peripheral model that sets done 3 clocks after init=1; op_a=3, op_b=5 -> write sequence 0C/0, 04/3, 08/5, 0C/1 in 4 consecutive cycles. Polls follow, then read 10. Final write 0C/0, then valid=1, result=32'd15, timeout_err=0.
- Max operands: op_a=op_b=16'hFFFF -> result=32'hFFFE0001. With done ready on the first poll, valid arrives exactly 10 cycles after the start edge.
- Timeout, TIMEOUT=8, model never sets done -> exactly 8 done reads, then write 0C/0. Then valid=1, timeout_err=1, result=0.
- start pulsed while busy (e.g. during POLL_REQ) with op_a=7 -> ignored; the in-flight operation completes with the original operands.
- Assert reset=0 mid-poll -> bus_cs/rd/wr and busy fall without a clock edge. After release, a start with 2x9 yields result=32'd18.
- Back-to-back: start held high for two ops, 4x4 then 6x7 -> two valid pulses with results 16 and 42. The second start is accepted the cycle after the first valid.
